// File: rtl/if_stage_pc_ifid.sv
// Instruction-fetch stage: program counter, instruction-memory address and the
// IF/ID pipeline register, with stall, redirect and flush handling.
module if_stage_pc_ifid #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Flush,
  input  logic [31:0] InstrIn,
  output logic [31:0] ImemAddress,
  output logic [31:0] PCPlus4,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid
);

  localparam logic [31:0] ALIGN_MASK = ~32'd3;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
  logic        ifid_valid_q, ifid_valid_d;

  assign pc_plus4 = pc_q + 32'd4;

  // A resolved redirect must never be lost, so it outranks a stall.
  always_comb begin
    pc_d = pc_plus4;
    if (Redirect) begin
      pc_d = RedirectTarget & ALIGN_MASK;
    end else if (Stall) begin
      pc_d = pc_q;
    end
  end

  // Redirect squashes the wrong-path fetch exactly like an explicit flush.
  always_comb begin
    ifid_instr_d   = InstrIn;
    ifid_pcplus4_d = pc_plus4;
    ifid_valid_d   = 1'b1;
    if (Flush || Redirect) begin
      ifid_instr_d   = NOP_WORD;
      ifid_pcplus4_d = '0;
      ifid_valid_d   = 1'b0;
    end else if (Stall) begin
      ifid_instr_d   = ifid_instr_q;
      ifid_pcplus4_d = ifid_pcplus4_q;
      ifid_valid_d   = ifid_valid_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q           <= RESET_PC & ALIGN_MASK;
      ifid_instr_q   <= NOP_WORD;
      ifid_pcplus4_q <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end

  assign ImemAddress      = pc_q;
  assign PCPlus4          = pc_plus4;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pcplus4_q;
  assign IFID_Valid       = ifid_valid_q;

endmodule

// File: tb/tb_if_stage_pc_ifid.sv
// Scoreboard bench for if_stage_pc_ifid: directed vectors push hand-computed
// post-edge state; a monitor pops and compares one entry per clock.
module tb_if_stage_pc_ifid;

  typedef struct {
    bit          sel;     // 0: RESET_PC=0 instance, 1: RESET_PC=FFFF_FFFC instance
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] tgt = '0;
  logic        flush = 1'b0;

  logic [31:0] addr_a, p4c_a, instr_a, ifi_a, ifp_a;
  logic [31:0] addr_b, p4c_b, instr_b, ifi_b, ifp_b;
  logic        v_a, v_b;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at byte address A holds 3*(A/4).
  assign instr_a = (addr_a >> 2) * 32'd3;
  assign instr_b = (addr_b >> 2) * 32'd3;

  if_stage_pc_ifid #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut_a (
    .Clk(clk), .Reset(rst), .Stall(stall), .Redirect(redir), .RedirectTarget(tgt),
    .Flush(flush), .InstrIn(instr_a), .ImemAddress(addr_a), .PCPlus4(p4c_a),
    .IFID_Instruction(ifi_a), .IFID_PCPlus4(ifp_a), .IFID_Valid(v_a)
  );

  if_stage_pc_ifid #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0000)) dut_b (
    .Clk(clk), .Reset(rst), .Stall(stall), .Redirect(redir), .RedirectTarget(tgt),
    .Flush(flush), .InstrIn(instr_b), .ImemAddress(addr_b), .PCPlus4(p4c_b),
    .IFID_Instruction(ifi_b), .IFID_PCPlus4(ifp_b), .IFID_Valid(v_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL vec%0d %s: got %h expected %h", vectors, name, act, req);
    end
  endtask

  // Monitor: state settles after each rising edge, sample 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk("pc",      addr_a, e.pc);
          chk("pcplus4", p4c_a,  e.pc + 32'd4);
          chk("instr",   ifi_a,  e.instr);
          chk("ifid_p4", ifp_a,  e.p4);
          chk("valid",   {31'd0, v_a}, {31'd0, e.valid});
        end else begin
          chk("b_pc",      addr_b, e.pc);
          chk("b_pcplus4", p4c_b,  e.pc + 32'd4);
          chk("b_instr",   ifi_b,  e.instr);
          chk("b_ifid_p4", ifp_b,  e.p4);
          chk("b_valid",   {31'd0, v_b}, {31'd0, e.valid});
        end
        vectors++;
      end
    end
  end

  task automatic vec(input bit r, input bit s, input bit rd, input logic [31:0] t,
                     input bit f, input bit sel, input logic [31:0] pc,
                     input logic [31:0] ins, input logic [31:0] p4, input bit v);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redir = rd; tgt = t; flush = f;
    e.sel = sel; e.pc = pc; e.instr = ins; e.p4 = p4; e.valid = v;
    q.push_back(e);
  endtask

  initial begin
    //   rst stl rdr target        fl sel pc             instr          ifid_p4        v
    // reset then free-run
    vec(1, 0, 0, 32'h0,        0, 0, 32'h0000_0000, 32'd0,         32'h0,         0);
    vec(1, 0, 0, 32'h0,        0, 0, 32'h0000_0000, 32'd0,         32'h0,         0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0004, 32'd0,         32'h4,         1);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0008, 32'd3,         32'h8,         1);
    // stall three cycles at PC=8
    vec(0, 1, 0, 32'h0,        0, 0, 32'h0000_0008, 32'd3,         32'h8,         1);
    vec(0, 1, 0, 32'h0,        0, 0, 32'h0000_0008, 32'd3,         32'h8,         1);
    vec(0, 1, 0, 32'h0,        0, 0, 32'h0000_0008, 32'd3,         32'h8,         1);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_000C, 32'd6,         32'hC,         1);
    // flush only at PC=12
    vec(0, 0, 0, 32'h0,        1, 0, 32'h0000_0010, 32'd0,         32'h0,         0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0014, 32'd12,        32'h14,        1);
    // redirect to misaligned 0x43
    vec(0, 0, 1, 32'h0000_0043, 0, 0, 32'h0000_0040, 32'd0,        32'h0,         0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0044, 32'd48,        32'h44,        1);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0048, 32'd51,        32'h48,        1);
    // redirect during stall
    vec(0, 1, 1, 32'h0000_0020, 0, 0, 32'h0000_0020, 32'd0,        32'h0,         0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0024, 32'd24,        32'h24,        1);
    // stall with flush: PC holds, IF/ID squashed
    vec(0, 1, 0, 32'h0,        1, 0, 32'h0000_0024, 32'd0,         32'h0,         0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0028, 32'd27,        32'h28,        1);
    // reset beats redirect and stall
    vec(1, 1, 1, 32'h0000_0080, 0, 0, 32'h0000_0000, 32'd0,        32'h0,         0);
    vec(0, 0, 0, 32'h0,        0, 0, 32'h0000_0004, 32'd0,         32'h4,         1);
    // wrap with RESET_PC=FFFF_FFFC
    vec(1, 1, 1, 32'h0000_0080, 0, 1, 32'hFFFF_FFFC, 32'd0,        32'h0,         0);
    vec(0, 0, 0, 32'h0,        0, 1, 32'h0000_0000, 32'hBFFF_FFFD, 32'h0,         1);
    vec(0, 0, 0, 32'h0,        0, 1, 32'h0000_0004, 32'd0,         32'h4,         1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
